// File: rtl/rr_arbiter16_if.sv
// rr_arbiter16_if: request/grant bundle between requesters and the 16-way arbiter
interface rr_arbiter16_if;
    logic        en;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_vld;
    logic        busy;
    modport master (output en, req, done, input gnt, gnt_idx, gnt_vld, busy);
    modport slave  (input en, req, done, output gnt, gnt_idx, gnt_vld, busy);
endinterface

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-way round-robin arbiter with hold limit and mandatory idle gap between owners
module rr_arbiter16 #(
    parameter int MAX_HOLD = 8
) (
    input logic            clk,
    input logic            rst,
    rr_arbiter16_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t      state;
    logic [3:0]  ptr;
    logic [3:0]  nxt;
    logic [7:0]  hold;
    logic        found;
    logic        rel;
    // Descending scan so the smallest offset from ptr wins
    always_comb begin
        nxt = '0;
        found = |bus.req;
        for (int k = 15; k >= 0; k--)
            if (bus.req[ptr + 4'(k)]) nxt = ptr + 4'(k);
    end
    assign rel = bus.done | ~bus.req[bus.gnt_idx] | ~bus.en | (hold == 8'(MAX_HOLD - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold        <= '0;
            bus.gnt     <= '0;
            bus.gnt_idx <= '0;
            bus.gnt_vld <= 1'b0;
            bus.busy    <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.en && found) begin
                state       <= GRANT;
                bus.gnt     <= 16'h0001 << nxt;
                bus.gnt_idx <= nxt;
                bus.gnt_vld <= 1'b1;
                bus.busy    <= 1'b1;
                ptr         <= nxt + 4'd1;
                hold        <= '0;
            end
        end else if (rel) begin
            state       <= IDLE;
            bus.gnt     <= '0;
            bus.gnt_vld <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            hold <= hold + 8'd1;
        end
    end
endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: directed vectors with hand-computed grants for rr_arbiter16
module tb_rr_arbiter16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;
    always #5 clk = ~clk;
    rr_arbiter16_if bus();
    rr_arbiter16 #(.MAX_HOLD(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic expect_out(input string tag, input logic [15:0] g, input logic [3:0] i, input logic v);
        check({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        check({tag, ".idx"}, 32'(bus.gnt_idx), 32'(i));
        check({tag, ".vld"}, 32'(bus.gnt_vld), 32'(v));
        check({tag, ".busy"}, 32'(bus.busy), 32'(v));
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.en = 1'b0;
        bus.req = '0;
        bus.done = 1'b0;
        tick;
        tick;
        expect_out("reset", 16'h0000, 4'h0, 1'b0);
        rst = 1'b0;
        // single requester, done on third grant cycle
        bus.req = 16'h0001;
        bus.en = 1'b1;
        tick;
        expect_out("single.c1", 16'h0001, 4'h0, 1'b1);
        tick;
        expect_out("single.c2", 16'h0001, 4'h0, 1'b1);
        bus.done = 1'b1;
        tick;
        expect_out("single.rel", 16'h0000, 4'h0, 1'b0);
        bus.done = 1'b0;
        bus.req = 16'h0000;
        tick;
        expect_out("single.idle", 16'h0000, 4'h0, 1'b0);
        // all requesting, done held: full rotation with idle gaps
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.req = 16'hFFFF;
        bus.done = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            tick;
            expect_out($sformatf("rot%0d", i), 16'h0001 << (i % 16), 4'(i % 16), 1'b1);
            tick;
            check($sformatf("rot%0d.gap", i), 32'(bus.gnt_vld), 32'd0);
        end
        bus.req = 16'h0000;
        bus.done = 1'b0;
        // hold limit: 8 grant cycles, one idle, regrant
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.req = 16'h0020;
        tick;
        expect_out("hold.c1", 16'h0020, 4'h5, 1'b1);
        for (int k = 2; k <= 8; k++) begin
            tick;
            check($sformatf("hold.c%0d", k), 32'(bus.gnt), 32'h0020);
        end
        tick;
        expect_out("hold.gap", 16'h0000, 4'h5, 1'b0);
        tick;
        expect_out("hold.regrant", 16'h0020, 4'h5, 1'b1);
        bus.req = 16'h0000;
        tick;
        check("hold.drop", 32'(bus.gnt_vld), 32'd0);
        // wrap search: owner 3, ptr 4, req 0x0009 -> index 0
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.req = 16'h0008;
        tick;
        expect_out("wrap.own3", 16'h0008, 4'h3, 1'b1);
        bus.req = 16'h0009;
        bus.done = 1'b1;
        tick;
        expect_out("wrap.rel", 16'h0000, 4'h3, 1'b0);
        bus.done = 1'b0;
        tick;
        expect_out("wrap.next", 16'h0001, 4'h0, 1'b1);
        bus.req = 16'h0000;
        tick;
        // reset mid-grant of index 7
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.req = 16'h0080;
        tick;
        expect_out("rst.own7", 16'h0080, 4'h7, 1'b1);
        rst = 1'b1;
        bus.req = 16'h0081;
        tick;
        expect_out("rst.mid", 16'h0000, 4'h0, 1'b0);
        rst = 1'b0;
        tick;
        expect_out("rst.first", 16'h0001, 4'h0, 1'b1);
        bus.req = 16'h0000;
        tick;
        // enable drop mid-grant, resume at ptr
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.req = 16'hFFFF;
        tick;
        expect_out("en.own0", 16'h0001, 4'h0, 1'b1);
        bus.en = 1'b0;
        tick;
        expect_out("en.drop", 16'h0000, 4'h0, 1'b0);
        tick;
        tick;
        expect_out("en.blocked", 16'h0000, 4'h0, 1'b0);
        bus.en = 1'b1;
        tick;
        expect_out("en.resume", 16'h0002, 4'h1, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
